collatz_engine: RTL and testbench
=================================

// Module: collatz_engine
// PURPOSE
//  Self-sequenced, parametrised Collatz iterator with its own control FSM.
//  Accepts a seed on a start strobe and iterates k -> k/2 (even) or 3k+1 (odd) at one step per clock.
//  Reports step count, peak value, overflow and timeout, and pulses done on completion.
//  Top-level instances drive it directly; no external micro-sequencer (mux/load/shift strobes) is needed.
// PARAMETERS
//  W         20    value width (seed, k, peak), W>=4
//  CW        16    step counter width
//  MAX_STEPS 1000  step cap before timeout; must be < 2**CW
//  SHORTCUT  0     1: odd step computes (3k+1)/2 and counts as one step
// PORTS
//  clk       in   1   rising-edge clock
//  rst       in   1   asynchronous, active-high reset
//  start     in   1   request; sampled only in IDLE
//  seed      in   W   start value, captured when start is accepted
//  busy      out  1   high while in RUN
//  done      out  1   one-cycle pulse, high in the first IDLE cycle after completion
//  value     out  W   current k
//  steps     out  CW  steps executed
//  peak      out  W   maximum k reached, including the seed
//  overflow  out  1   next odd result does not fit in W bits
//  timeout   out  1   MAX_STEPS reached with k!=1
//  err_zero  out  1   seed was 0
// BEHAVIOUR
//  - Reset (any time, including mid-run): state=IDLE; every output and register = 0.
//  - States: IDLE, RUN. Outputs are registered.
//  - IDLE with start=1 at edge t:
//    - Clears done, overflow, timeout and err_zero.
//    - seed==0: err_zero<=1, done<=1, stay IDLE; value, steps and peak are unchanged.
//    - else: value<=seed, peak<=seed, steps<=0, busy<=1, go to RUN.
//  - RUN, per edge, in priority order:
//    1) value==1: finish.
//    2) steps==MAX_STEPS: timeout<=1, finish.
//    3) value even: value<=value>>1; steps++.
//    4) value odd: t=3*value+1 computed in W+2 bits; r = SHORTCUT ? t>>1 : t.
//       - r[W+1:W]!=0: overflow<=1, finish; value and steps are unchanged.
//       - else: value<=r[W-1:0]; steps++; peak<=max(peak, r).
//  - Finish: done<=1, busy<=0, state<=IDLE.
//  - done drops on the next edge.
//  - steps, value, peak and flags hold until the next accepted start.
//  - Latency: start edge to done high = steps+1 clocks.
//  - start while busy is ignored.
//  - start in the same cycle as done=1 is accepted (the state is IDLE).
//  - Even steps never raise peak; with SHORTCUT, peak tracks stored values only.
// TESTING
//  1. seed=1 -> done 2 clocks after start; steps=0, peak=1, all flags 0.
//  2. seed=6, SHORTCUT=0 -> steps=8, peak=16, value=1; busy high for exactly 9 cycles.
//  3. seed=27, W=20 -> steps=111, peak=9232; with SHORTCUT=1 -> steps=70, peak=4616.
//  4. W=8, seed=255 -> overflow=1, steps=0, value=255, done pulse.
//     seed=0 -> err_zero=1, done in the next cycle.
//  5. MAX_STEPS=10, seed=27 -> timeout=1, steps=10, done asserted.
//     Restart with seed=6 in the same cycle as done -> timeout cleared, steps=8.
//  6. Assert rst mid-run with seed=27 -> all outputs 0 immediately.
//     Start pulses while busy -> ignored; result matches a single run.

Source files
------------

// File: rtl/collatz_engine.sv
// Self-sequenced Collatz iterator: accepts a seed on start, steps once per clock,
// and reports steps, peak, overflow/timeout/zero-seed flags with a done pulse.
module collatz_engine #(
    parameter int W         = 20,
    parameter int CW        = 16,
    parameter int MAX_STEPS = 1000,
    parameter int SHORTCUT  = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  seed,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  value,
    output logic [CW-1:0] steps,
    output logic [W-1:0]  peak,
    output logic          overflow,
    output logic          timeout,
    output logic          err_zero
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CW-1:0] MAX_C = CW'(MAX_STEPS);

    state_t        state_q, state_d;
    logic [W-1:0]  value_q, value_d;
    logic [W-1:0]  peak_q, peak_d;
    logic [CW-1:0] steps_q, steps_d;
    logic          done_q, done_d;
    logic          overflow_q, overflow_d;
    logic          timeout_q, timeout_d;
    logic          err_zero_q, err_zero_d;

    logic [W+1:0]  k_ext;
    logic [W+1:0]  t_w;
    logic [W+1:0]  r_w;

    // Two guard bits hold 3k+1 for any W-bit k; nonzero guard bits after the
    // optional halving mean the result cannot be stored.
    always_comb begin
        k_ext = {2'b00, value_q};
        t_w   = (k_ext << 1) + k_ext + {{(W+1){1'b0}}, 1'b1};
        r_w   = (SHORTCUT != 0) ? (t_w >> 1) : t_w;
    end

    always_comb begin
        state_d    = state_q;
        value_d    = value_q;
        peak_d     = peak_q;
        steps_d    = steps_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        timeout_d  = timeout_q;
        err_zero_d = err_zero_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    overflow_d = 1'b0;
                    timeout_d  = 1'b0;
                    err_zero_d = 1'b0;
                    if (seed == '0) begin
                        err_zero_d = 1'b1;
                        done_d     = 1'b1;
                    end else begin
                        value_d = seed;
                        peak_d  = seed;
                        steps_d = '0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (value_q == W'(1)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (steps_q == MAX_C) begin
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end else if (!value_q[0]) begin
                    value_d = value_q >> 1;
                    steps_d = steps_q + CW'(1);
                end else if (r_w[W+1:W] != 2'b00) begin
                    overflow_d = 1'b1;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end else begin
                    value_d = r_w[W-1:0];
                    steps_d = steps_q + CW'(1);
                    if (r_w[W-1:0] > peak_q) peak_d = r_w[W-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            value_q    <= '0;
            peak_q     <= '0;
            steps_q    <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
            err_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            value_q    <= value_d;
            peak_q     <= peak_d;
            steps_q    <= steps_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
            err_zero_q <= err_zero_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = done_q;
    assign value    = value_q;
    assign steps    = steps_q;
    assign peak     = peak_q;
    assign overflow = overflow_q;
    assign timeout  = timeout_q;
    assign err_zero = err_zero_q;

endmodule

// File: tb/tb_collatz_engine.sv
// Directed bench for collatz_engine: four instances cover plain, shortcut,
// narrow-width and short step-cap configurations.
module tb_collatz_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start [4];
    logic [19:0] seed  [4];
    logic        busy  [4];
    logic        done  [4];
    logic [19:0] value [4];
    logic [19:0] peak  [4];
    logic [15:0] steps [4];
    logic        ovf   [4];
    logic        tmo   [4];
    logic        ez    [4];
    logic [7:0]  value8, peak8;

    assign value[2] = {12'b0, value8};
    assign peak[2]  = {12'b0, peak8};

    int n_checks = 0;
    int n_err    = 0;

    collatz_engine #(.W(20), .CW(16), .MAX_STEPS(1000), .SHORTCUT(0)) u0 (
        .clk(clk), .rst(rst), .start(start[0]), .seed(seed[0]), .busy(busy[0]),
        .done(done[0]), .value(value[0]), .steps(steps[0]), .peak(peak[0]),
        .overflow(ovf[0]), .timeout(tmo[0]), .err_zero(ez[0]));

    collatz_engine #(.W(20), .CW(16), .MAX_STEPS(1000), .SHORTCUT(1)) u1 (
        .clk(clk), .rst(rst), .start(start[1]), .seed(seed[1]), .busy(busy[1]),
        .done(done[1]), .value(value[1]), .steps(steps[1]), .peak(peak[1]),
        .overflow(ovf[1]), .timeout(tmo[1]), .err_zero(ez[1]));

    collatz_engine #(.W(8), .CW(16), .MAX_STEPS(1000), .SHORTCUT(0)) u2 (
        .clk(clk), .rst(rst), .start(start[2]), .seed(seed[2][7:0]), .busy(busy[2]),
        .done(done[2]), .value(value8), .steps(steps[2]), .peak(peak8),
        .overflow(ovf[2]), .timeout(tmo[2]), .err_zero(ez[2]));

    collatz_engine #(.W(20), .CW(16), .MAX_STEPS(10), .SHORTCUT(0)) u3 (
        .clk(clk), .rst(rst), .start(start[3]), .seed(seed[3]), .busy(busy[3]),
        .done(done[3]), .value(value[3]), .steps(steps[3]), .peak(peak[3]),
        .overflow(ovf[3]), .timeout(tmo[3]), .err_zero(ez[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drives a one-cycle start and returns at the first negedge where done is high.
    // lat counts posedges from the start edge inclusive; bsy counts busy cycles.
    task automatic run(input int i, input logic [19:0] s, output int lat, output int bsy);
        start[i] = 1'b1;
        seed[i]  = s;
        lat = 0;
        bsy = 0;
        @(negedge clk);
        start[i] = 1'b0;
        lat = 1;
        while (!done[i] && lat < 3000) begin
            if (busy[i]) bsy++;
            @(negedge clk);
            lat++;
        end
        if (!done[i]) chk("done_wait_bound", 32'(lat), 32'd0);
    endtask

    task automatic chk_all(input string tag, input int i, input logic [19:0] v,
                           input logic [15:0] st, input logic [19:0] pk,
                           input logic o, input logic t, input logic z);
        chk({tag, "_value"}, 32'(value[i]), 32'(v));
        chk({tag, "_steps"}, 32'(steps[i]), 32'(st));
        chk({tag, "_peak"},  32'(peak[i]),  32'(pk));
        chk({tag, "_ovf"},   32'(ovf[i]),   32'(o));
        chk({tag, "_tmo"},   32'(tmo[i]),   32'(t));
        chk({tag, "_ez"},    32'(ez[i]),    32'(z));
    endtask

    initial begin
        int lat, bsy, guard;
        for (int i = 0; i < 4; i++) begin
            start[i] = 1'b0;
            seed[i]  = '0;
        end
        repeat (2) @(negedge clk);
        chk_all("rst", 0, 20'd0, 16'd0, 20'd0, 1'b0, 1'b0, 1'b0);
        chk("rst_busy", 32'(busy[0]), 32'd0);
        chk("rst_done", 32'(done[0]), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // seed=1 finishes on the edge after the start edge
        run(0, 20'd1, lat, bsy);
        chk("s1_lat", 32'(lat), 32'd2);
        chk_all("s1", 0, 20'd1, 16'd0, 20'd1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("s1_done_drop", 32'(done[0]), 32'd0);

        run(0, 20'd6, lat, bsy);
        chk("s6_lat", 32'(lat), 32'd10);
        chk("s6_busy_cycles", 32'(bsy), 32'd9);
        chk_all("s6", 0, 20'd1, 16'd8, 20'd16, 1'b0, 1'b0, 1'b0);
        chk("s6_busy_low", 32'(busy[0]), 32'd0);

        run(0, 20'd27, lat, bsy);
        chk_all("s27", 0, 20'd1, 16'd111, 20'd9232, 1'b0, 1'b0, 1'b0);
        chk("s27_lat", 32'(lat), 32'd113);

        run(1, 20'd27, lat, bsy);
        chk_all("s27sc", 1, 20'd1, 16'd70, 20'd4616, 1'b0, 1'b0, 1'b0);

        // 3*255+1 does not fit in 8 bits
        run(2, 20'd255, lat, bsy);
        chk_all("ovf8", 2, 20'd255, 16'd0, 20'd255, 1'b1, 1'b0, 1'b0);
        chk("ovf8_lat", 32'(lat), 32'd2);
        @(negedge clk);

        // zero seed: flags cleared/raised, data registers untouched
        run(2, 20'd0, lat, bsy);
        chk("zero_lat", 32'(lat), 32'd1);
        chk("zero_busy", 32'(bsy), 32'd0);
        chk_all("zero", 2, 20'd255, 16'd0, 20'd255, 1'b0, 1'b0, 1'b1);

        // 27 after 10 steps is 214
        run(3, 20'd27, lat, bsy);
        chk_all("tmo", 3, 20'd214, 16'd10, 20'd214, 1'b0, 1'b1, 1'b0);
        chk("tmo_lat", 32'(lat), 32'd12);
        // restart in the done cycle
        run(3, 20'd6, lat, bsy);
        chk("restart_lat", 32'(lat), 32'd10);
        chk_all("restart", 3, 20'd1, 16'd8, 20'd16, 1'b0, 1'b0, 1'b0);

        // asynchronous reset mid-run
        start[0] = 1'b1;
        seed[0]  = 20'd27;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (20) @(negedge clk);
        chk("midrun_busy", 32'(busy[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk_all("arst", 0, 20'd0, 16'd0, 20'd0, 1'b0, 1'b0, 1'b0);
        chk("arst_busy", 32'(busy[0]), 32'd0);
        chk("arst_done", 32'(done[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // start pulses during RUN must not disturb the seed=6 run
        start[0] = 1'b1;
        seed[0]  = 20'd6;
        @(negedge clk);
        start[0] = 1'b0;
        @(negedge clk);
        start[0] = 1'b1;
        seed[0]  = 20'd27;
        repeat (2) @(negedge clk);
        start[0] = 1'b0;
        guard = 0;
        while (!done[0] && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        chk("busy_start_done_seen", 32'(done[0]), 32'd1);
        chk_all("busy_start", 0, 20'd1, 16'd8, 20'd16, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
